tag_cam_match: RTL and testbench
================================

Name: tag_cam_match

Overview:
- Parametrised tag-match CAM. Each of DEPTH entries holds a TAG_W-bit tag and a valid bit.
- A registered search compares one key against all valid entries in parallel.
- Returns a hit vector, a lowest-index priority hit index, and a multi-hit flag, one cycle later.
- Serves as the match stage for rename/dependency and small tag-lookup structures. It generalises the 3-bit equality comparator to N entries, with storage, invalidate and flush.

Parameters:
- TAG_W, 3, tag width in bits (>=1)
- DEPTH, 8, number of entries (2..64)
- IDX_W, 3, index width; must equal clog2(DEPTH), checked by an elaboration assertion

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write entry wr_idx with wr_tag, set its valid bit
- wr_idx  in  IDX_W  write target index
- wr_tag  in  TAG_W  write data
- inv_en  in  1  clear valid bit of entry inv_idx
- inv_idx  in  IDX_W  invalidate target index
- flush  in  1  clear all valid bits
- srch_en  in  1  search request this cycle
- srch_tag  in  TAG_W  search key
- rsp_valid  out  1  registered; high one cycle after srch_en
- hit  out  1  registered; at least one valid entry matched
- hit_idx  out  IDX_W  registered; lowest matching index, 0 when no hit
- hit_vec  out  DEPTH  registered; per-entry match mask
- multi_hit  out  1  registered; two or more entries matched

Behaviour:
- Reset (rst_n low, asynchronous): all valid bits 0, all tags 0, rsp_valid/hit/hit_idx/hit_vec/multi_hit 0. Reset dominates everything, including mid-search; a search issued in the cycle reset asserts produces no response.
- Match for entry i = valid[i] AND (tag[i] == srch_tag), evaluated on pre-edge state.
- Latency: a search in cycle N produces registered outputs in cycle N+1.
- rsp_valid = srch_en delayed one cycle. When srch_en was 0, hit/hit_idx/hit_vec/multi_hit are driven 0 (not held).
- Priority: hit_idx is the lowest set bit of hit_vec. multi_hit = popcount(hit_vec) >= 2.
- Storage update precedence on the same edge:
  - flush > write > invalidate.
  - flush with wr_en: flush wins; the write is dropped and the tag array is unchanged.
  - wr_en and inv_en to the same index: the entry ends valid with wr_tag.
  - wr_en and inv_en to different indices: both take effect.
- Out-of-range index (wr_idx or inv_idx >= DEPTH, possible when DEPTH is not a power of 2): the operation is ignored.
- Write/search collision (same cycle, without the optional feature): the search sees pre-write contents. The write becomes visible to searches from the next cycle.
- Rewriting a valid entry with a new tag overwrites it silently. Duplicate tags are legal and are reported via multi_hit.
- No back-pressure: one search accepted every cycle, fully pipelined.

Optional Feature:
- Macro: TAG_CAM_BYPASS_EN.
- Defined: a same-cycle write is forwarded into the search. Entry wr_idx is compared as valid with tag wr_tag, overriding the stored state. Flush still wins: no forwarding when flush=1. Same-index invalidate does not block forwarding, since write wins.
- Undefined: pre-write contents are searched, as specified above.

Decomposition:
- Package tag_cam_pkg:
  - default TAG_W/DEPTH constants
  - clog2 function
  - priority-encode function (lowest set bit to index)
  - popcount>=2 function
- One sub-module: tag_eq_cmp, a parametrised TAG_W equality comparator (XNOR per bit, AND-reduce tree). Instantiated DEPTH times via generate.
- Top level holds the storage registers, precedence logic, output registers and optional bypass.

Test Plan:
- Reset, then search 3'b101 -> cycle+1: rsp_valid=1, hit=0, hit_idx=0, hit_vec=0, multi_hit=0.
- Write idx2=5, idx6=5; search 5 next cycle -> hit=1, hit_idx=2, hit_vec=8'h44, multi_hit=1. Invalidate idx2, search 5 -> hit_idx=6, hit_vec=8'h40, multi_hit=0.
- Same cycle: write idx1=3 and search 3 -> without TAG_CAM_BYPASS_EN: hit=0. With TAG_CAM_BYPASS_EN: hit=1, hit_idx=1, hit_vec=8'h02.
- Fill all 8 entries with tag=idx, then same cycle: flush and write idx4=7 -> a search of 7 and a search of 4 both miss. wr_en+inv_en both to idx3 with tag 2 -> a search of 2 gives hit_idx=3.
- Back-to-back searches 0,1,2 (all present) -> rsp_valid stays high 3 cycles, hit_idx=0,1,2 in order. Drop srch_en -> rsp_valid=0 and all outputs 0 the next cycle.
- Assert rst_n low asynchronously mid-cycle during back-to-back searches -> outputs go to 0 immediately. After release, a search of a previously written tag misses.

Source files
------------

// File: rtl/tag_cam_pkg.sv
// ---------------------------------------------------------------------------
// tag_cam_pkg
// Shared constants and helper functions for the tag-match CAM.
//   TAG_W_DEF / DEPTH_DEF : default geometry
//   MAX_DEPTH / MAX_IDX_W : widest vector the helper functions accept
//   clog2()     : ceiling log2, used to validate IDX_W at elaboration
//   prio_enc()  : lowest set bit -> index (0 when the vector is empty)
//   multi_set() : true when two or more bits are set
// ---------------------------------------------------------------------------
package tag_cam_pkg;

    localparam int TAG_W_DEF = 3;
    localparam int DEPTH_DEF = 8;
    localparam int MAX_DEPTH = 64;
    localparam int MAX_IDX_W = 6;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Scan from the top down so the last assignment is the lowest set bit.
    function automatic logic [MAX_IDX_W-1:0] prio_enc(input logic [MAX_DEPTH-1:0] v);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_DEPTH - 1; i >= 0; i--) begin
            if (v[i]) idx = MAX_IDX_W'(i);
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves something only if >= 2 bits were set.
    function automatic logic multi_set(input logic [MAX_DEPTH-1:0] v);
        return |(v & (v - MAX_DEPTH'(1)));
    endfunction

endpackage

// File: rtl/tag_eq_cmp.sv
// ---------------------------------------------------------------------------
// tag_eq_cmp
// Combinational TAG_W-bit equality comparator: per-bit XNOR, AND-reduced.
//   a_i  [TAG_W] : stored tag
//   b_i  [TAG_W] : search key
//   eq_o         : 1 when a_i == b_i
// ---------------------------------------------------------------------------
module tag_eq_cmp #(
    parameter int TAG_W = 3
) (
    input  logic [TAG_W-1:0] a_i,
    input  logic [TAG_W-1:0] b_i,
    output logic             eq_o
);

    logic [TAG_W-1:0] bit_eq;

    assign bit_eq = ~(a_i ^ b_i);
    assign eq_o   = &bit_eq;

endmodule

// File: rtl/tag_cam_match.sv
// ---------------------------------------------------------------------------
// tag_cam_match
// DEPTH-entry tag CAM with write / invalidate / flush and a registered
// parallel search returning hit, lowest-index hit, hit mask and multi-hit.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   wr_en/wr_idx/wr_tag   : write tag into entry, mark valid
//   inv_en/inv_idx        : clear valid bit of entry
//   flush                 : clear every valid bit
//   srch_en/srch_tag      : search request and key
//   rsp_valid             : srch_en delayed one cycle
//   hit/hit_idx/hit_vec/multi_hit : registered search result (0 when idle)
//
// Build option:
//   TAG_CAM_BYPASS_EN : forward a same-cycle write into the search
//                       (suppressed when flush is asserted).
// ---------------------------------------------------------------------------
module tag_cam_match
    import tag_cam_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_idx,
    input  logic             flush,
    input  logic             srch_en,
    input  logic [TAG_W-1:0] srch_tag,
    output logic             rsp_valid,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx,
    output logic [DEPTH-1:0] hit_vec,
    output logic             multi_hit
);

    // Geometry sanity checks at elaboration.
    if (IDX_W != clog2(DEPTH)) begin : g_bad_idx_w
        $error("tag_cam_match: IDX_W must equal clog2(DEPTH)");
    end
    if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("tag_cam_match: DEPTH must be in 2..64");
    end
    if (TAG_W < 1) begin : g_bad_tag_w
        $error("tag_cam_match: TAG_W must be >= 1");
    end

    // Storage.
    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;

    // Per-entry decode and compare.
    logic [DEPTH-1:0]            wr_sel;
    logic [DEPTH-1:0]            inv_sel;
    logic [DEPTH-1:0]            cmp_vld;
    logic [DEPTH-1:0][TAG_W-1:0] cmp_tag;
    logic [DEPTH-1:0]            eq;
    logic [DEPTH-1:0]            match;

    // Output registers.
    logic             rsp_valid_q, rsp_valid_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
    logic [DEPTH-1:0] hit_vec_q, hit_vec_d;
    logic             multi_hit_q, multi_hit_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        // Index compare against i only: an index >= DEPTH selects nothing,
        // so out-of-range writes/invalidates fall away naturally.
        assign wr_sel[i]  = wr_en  && (wr_idx  == IDX_W'(i));
        assign inv_sel[i] = inv_en && (inv_idx == IDX_W'(i));

`ifdef TAG_CAM_BYPASS_EN
        // Same-cycle write overrides stored state unless a flush kills it.
        logic fwd;
        assign fwd        = wr_sel[i] & ~flush;
        assign cmp_vld[i] = fwd | vld_q[i];
        assign cmp_tag[i] = fwd ? wr_tag : tag_q[i];
`else
        assign cmp_vld[i] = vld_q[i];
        assign cmp_tag[i] = tag_q[i];
`endif

        tag_eq_cmp #(
            .TAG_W (TAG_W)
        ) u_cmp (
            .a_i  (cmp_tag[i]),
            .b_i  (srch_tag),
            .eq_o (eq[i])
        );

        assign match[i] = cmp_vld[i] & eq[i];
    end

    // Storage next state: flush > write > invalidate. Flush leaves tags alone.
    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                vld_d[i] = 1'b0;
            end else if (wr_sel[i]) begin
                vld_d[i] = 1'b1;
                tag_d[i] = wr_tag;
            end else if (inv_sel[i]) begin
                vld_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
        end
    end

    // Result is zeroed when no search was issued rather than held.
    always_comb begin
        rsp_valid_d = srch_en;
        hit_vec_d   = '0;
        hit_d       = 1'b0;
        hit_idx_d   = '0;
        multi_hit_d = 1'b0;
        if (srch_en) begin
            hit_vec_d   = match;
            hit_d       = |match;
            hit_idx_d   = IDX_W'(prio_enc(MAX_DEPTH'(match)));
            multi_hit_d = multi_set(MAX_DEPTH'(match));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            hit_vec_q   <= '0;
            multi_hit_q <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            hit_q       <= hit_d;
            hit_idx_q   <= hit_idx_d;
            hit_vec_q   <= hit_vec_d;
            multi_hit_q <= multi_hit_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign hit       = hit_q;
    assign hit_idx   = hit_idx_q;
    assign hit_vec   = hit_vec_q;
    assign multi_hit = multi_hit_q;

endmodule

// File: tb/tb_tag_cam_match.sv
// ---------------------------------------------------------------------------
// tb_tag_cam_match
// Self-checking bench for tag_cam_match (TAG_W=3, DEPTH=8): a directed
// vector table, a mid-cycle asynchronous reset sequence, and a randomized
// phase checked against an array-based behavioural model.
// ---------------------------------------------------------------------------
module tb_tag_cam_match;

    localparam int TAG_W = 3;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             inv_en;
    logic [IDX_W-1:0] inv_idx;
    logic             flush;
    logic             srch_en;
    logic [TAG_W-1:0] srch_tag;
    logic             rsp_valid;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [DEPTH-1:0] hit_vec;
    logic             multi_hit;

    tag_cam_match #(
        .TAG_W (TAG_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_tag    (wr_tag),
        .inv_en    (inv_en),
        .inv_idx   (inv_idx),
        .flush     (flush),
        .srch_en   (srch_en),
        .srch_tag  (srch_tag),
        .rsp_valid (rsp_valid),
        .hit       (hit),
        .hit_idx   (hit_idx),
        .hit_vec   (hit_vec),
        .multi_hit (multi_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [2:0] wr_idx;
        logic [2:0] wr_tag;
        logic       inv_en;
        logic [2:0] inv_idx;
        logic       flush;
        logic       srch_en;
        logic [2:0] srch_tag;
        logic       e_vld;
        logic       e_hit;
        logic [2:0] e_idx;
        logic [7:0] e_vec;
        logic       e_multi;
    } vec_t;

    vec_t tbl[$];
    int   checks;
    int   fails;

    // Model state for the randomized phase.
    logic       m_vld[DEPTH];
    logic [2:0] m_tag[DEPTH];

    function automatic vec_t mk(input logic we, input logic [2:0] wi, input logic [2:0] wt,
                                input logic ie, input logic [2:0] ii, input logic fl,
                                input logic se, input logic [2:0] st,
                                input logic eh, input logic [2:0] ei, input logic [7:0] ev,
                                input logic em);
        vec_t v;
        v.wr_en = we;  v.wr_idx = wi;  v.wr_tag = wt;
        v.inv_en = ie; v.inv_idx = ii; v.flush = fl;
        v.srch_en = se; v.srch_tag = st;
        v.e_vld = se;  v.e_hit = eh;  v.e_idx = ei;  v.e_vec = ev;  v.e_multi = em;
        return v;
    endfunction

    task automatic drive(input logic we, input logic [2:0] wi, input logic [2:0] wt,
                         input logic ie, input logic [2:0] ii, input logic fl,
                         input logic se, input logic [2:0] st);
        wr_en = we;  wr_idx = wi;  wr_tag = wt;
        inv_en = ie; inv_idx = ii; flush = fl;
        srch_en = se; srch_tag = st;
    endtask

    task automatic check_out(input string name, input logic ev, input logic eh,
                             input logic [2:0] ei, input logic [7:0] evec, input logic em);
        checks++;
        if (rsp_valid !== ev || hit !== eh || hit_idx !== ei || hit_vec !== evec || multi_hit !== em) begin
            fails++;
            $display("FAIL %s: got vld=%0b hit=%0b idx=%0d vec=%02h multi=%0b, expected vld=%0b hit=%0b idx=%0d vec=%02h multi=%0b",
                     name, rsp_valid, hit, hit_idx, hit_vec, multi_hit, ev, eh, ei, evec, em);
        end
    endtask

    initial begin
        string nm;
        checks = 0;
        fails  = 0;

        // ---------------- directed table ----------------
        tbl.push_back(mk(0,0,0, 0,0, 0, 1,3'd5, 0,0,8'h00,0));  // 0 empty search
        tbl.push_back(mk(1,2,5, 0,0, 0, 0,0,    0,0,8'h00,0));  // 1 wr 2=5
        tbl.push_back(mk(1,6,5, 0,0, 0, 0,0,    0,0,8'h00,0));  // 2 wr 6=5
        tbl.push_back(mk(0,0,0, 0,0, 0, 1,3'd5, 1,2,8'h44,1));  // 3 dup hit
        tbl.push_back(mk(0,0,0, 1,2, 0, 0,0,    0,0,8'h00,0));  // 4 inv 2
        tbl.push_back(mk(0,0,0, 0,0, 0, 1,3'd5, 1,6,8'h40,0));  // 5
`ifdef TAG_CAM_BYPASS_EN
        tbl.push_back(mk(1,1,3, 0,0, 0, 1,3'd3, 1,1,8'h02,0));  // 6 collision, forwarded
`else
        tbl.push_back(mk(1,1,3, 0,0, 0, 1,3'd3, 0,0,8'h00,0));  // 6 collision, pre-write
`endif
        tbl.push_back(mk(0,0,0, 0,0, 0, 1,3'd3, 1,1,8'h02,0));  // 7 write now visible
        for (int i = 0; i < 8; i++)                               // 8..15 fill tag=idx
            tbl.push_back(mk(1,3'(i),3'(i), 0,0, 0, 0,0, 0,0,8'h00,0));
        tbl.push_back(mk(0,0,0, 0,0, 0, 1,3'd6, 1,6,8'h40,0));  // 16 overwrite took
        tbl.push_back(mk(1,4,7, 0,0, 1, 1,3'd7, 1,7,8'h80,0));  // 17 flush+wr, pre-edge search
        tbl.push_back(mk(0,0,0, 0,0, 0, 1,3'd7, 0,0,8'h00,0));  // 18 flushed, write dropped
        tbl.push_back(mk(0,0,0, 0,0, 0, 1,3'd4, 0,0,8'h00,0));  // 19
        tbl.push_back(mk(1,3,2, 1,3, 0, 0,0,    0,0,8'h00,0));  // 20 wr+inv same idx
        tbl.push_back(mk(0,0,0, 0,0, 0, 1,3'd2, 1,3,8'h08,0));  // 21 write won
        tbl.push_back(mk(1,5,2, 1,3, 0, 0,0,    0,0,8'h00,0));  // 22 wr+inv diff idx
        tbl.push_back(mk(0,0,0, 0,0, 0, 1,3'd2, 1,5,8'h20,0));  // 23 both applied
        tbl.push_back(mk(1,0,0, 0,0, 0, 0,0,    0,0,8'h00,0));  // 24
        tbl.push_back(mk(1,1,1, 0,0, 0, 0,0,    0,0,8'h00,0));  // 25
        tbl.push_back(mk(1,2,2, 1,5, 0, 0,0,    0,0,8'h00,0));  // 26
        tbl.push_back(mk(0,0,0, 0,0, 0, 1,3'd0, 1,0,8'h01,0));  // 27 back-to-back
        tbl.push_back(mk(0,0,0, 0,0, 0, 1,3'd1, 1,1,8'h02,0));  // 28
        tbl.push_back(mk(0,0,0, 0,0, 0, 1,3'd2, 1,2,8'h04,0));  // 29
        tbl.push_back(mk(0,0,0, 0,0, 0, 0,0,    0,0,8'h00,0));  // 30 idle -> zeros

        // Reset, with a search held high that must not produce a response.
        rst_n = 1'b0;
        drive(0,0,0, 0,0, 0, 1,3'd5);
        #1;
        check_out("reset_state_async", 0,0,0,8'h00,0);
        @(posedge clk); #1;
        check_out("reset_state_clocked", 0,0,0,8'h00,0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0,0,0, 0,0, 0, 0,0);

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].wr_en, tbl[k].wr_idx, tbl[k].wr_tag, tbl[k].inv_en, tbl[k].inv_idx,
                  tbl[k].flush, tbl[k].srch_en, tbl[k].srch_tag);
            @(posedge clk); #1;
            nm = $sformatf("vec%0d", k);
            check_out(nm, tbl[k].e_vld, tbl[k].e_hit, tbl[k].e_idx, tbl[k].e_vec, tbl[k].e_multi);
        end

        // ---------------- mid-cycle asynchronous reset ----------------
        @(negedge clk);
        drive(0,0,0, 0,0, 0, 1,3'd0);
        @(posedge clk); #1;
        check_out("pre_rst_search0", 1,1,0,8'h01,0);
        @(negedge clk);
        drive(0,0,0, 0,0, 0, 1,3'd1);
        @(posedge clk); #1;
        check_out("pre_rst_search1", 1,1,1,8'h02,0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst_immediate", 0,0,0,8'h00,0);
        @(posedge clk); #1;
        check_out("rst_held_search", 0,0,0,8'h00,0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0,0,0, 0,0, 0, 1,3'd0);
        @(posedge clk); #1;
        check_out("post_rst_miss", 1,0,0,8'h00,0);

        // ---------------- randomized vs model ----------------
        @(negedge clk);
        rst_n = 1'b0;
        drive(0,0,0, 0,0, 0, 0,0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            m_vld[i] = 1'b0;
            m_tag[i] = '0;
        end
        for (int n = 0; n < 1500; n++) begin
            logic       ev, eh, em;
            logic [2:0] ei;
            logic [7:0] evec;
            int         cnt;
            @(negedge clk);
            drive($urandom_range(0,9) < 4, 3'($urandom_range(0,7)), 3'($urandom_range(0,7)),
                  $urandom_range(0,9) < 2, 3'($urandom_range(0,7)),
                  $urandom_range(0,99) < 3,
                  $urandom_range(0,9) < 7, 3'($urandom_range(0,7)));
            // Expected response from the model's pre-edge view.
            evec = '0;
            for (int i = 0; i < DEPTH; i++) begin
                logic       v;
                logic [2:0] t;
                v = m_vld[i];
                t = m_tag[i];
`ifdef TAG_CAM_BYPASS_EN
                if (wr_en && !flush && wr_idx == 3'(i)) begin
                    v = 1'b1;
                    t = wr_tag;
                end
`endif
                if (srch_en && v && t == srch_tag) evec[i] = 1'b1;
            end
            ev  = srch_en;
            cnt = 0;
            ei  = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (evec[i]) begin
                    cnt++;
                    ei = 3'(i);
                end
            end
            eh = (cnt > 0);
            em = (cnt >= 2);
            // Model update: flush beats everything, write beats invalidate.
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
            end else begin
                if (inv_en) m_vld[inv_idx] = 1'b0;
                if (wr_en) begin
                    m_vld[wr_idx] = 1'b1;
                    m_tag[wr_idx] = wr_tag;
                end
            end
            @(posedge clk); #1;
            nm = $sformatf("rand%0d", n);
            check_out(nm, ev, eh, ei, evec, em);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
